// File: rtl/riscv_load_tag_prop.sv
// Load-side tag propagation: an in-order tracker of outstanding loads that merges the
// memory data tag with the base-address tag and writes the result to the RF tag bank.
module riscv_load_tag_prop #(
    parameter int DEPTH          = 2,
    parameter int LD_EN_SRC_BIT  = 18,
    parameter int LD_EN_ADDR_BIT = 19,
    parameter int LD_MODE_LSB    = 20,
    parameter int LD_CHECK_BIT   = 22
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] tpr_i,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic        ld_addr_tag_i,
    input  logic [5:0]  ld_rd_addr_i,
    input  logic        data_rvalid_i,
    input  logic        data_rtag_i,
    input  logic        data_err_i,
    output logic        rf_tag_we_o,
    output logic [5:0]  rf_tag_waddr_o,
    output logic        rf_tag_wdata_o,
    output logic        tag_exc_o,
    output logic        spurious_rvalid_o,
    output logic        busy_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Per-entry snapshot taken at issue so later TPR writes cannot affect in-flight loads.
    typedef struct packed {
        logic [5:0] rd;
        logic       addr_tag;
        logic       en_src;
        logic       en_addr;
        logic [1:0] mode;
        logic       check;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               r_we;
    logic [5:0]         r_waddr;
    logic               r_wdata;
    logic               r_exc;
    logic               r_spur;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [DEPTH-1:0]   w_wr_sel;
    entry_t             w_new;
    entry_t             w_head;
    logic               w_s;
    logic               w_a;
    logic               w_result;
    logic               w_trap;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    // ld_ready_o depends only on registered occupancy: no bypass when full.
    assign w_push  = ld_valid_i & ~w_full;
    assign w_pop   = data_rvalid_i & ~w_empty;

    assign w_new.rd       = ld_rd_addr_i;
    assign w_new.addr_tag = ld_addr_tag_i;
    assign w_new.en_src   = tpr_i[LD_EN_SRC_BIT];
    assign w_new.en_addr  = tpr_i[LD_EN_ADDR_BIT];
    assign w_new.mode     = tpr_i[LD_MODE_LSB +: 2];
    assign w_new.check    = tpr_i[LD_CHECK_BIT];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign w_wr_sel[gi] = w_push && (r_wr_ptr == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_wr_sel[i]) begin
                r_mem[i] <= w_new;
            end
        end
    end

    assign w_head = r_mem[r_rd_ptr];
    assign w_s    = w_head.en_src & data_rtag_i;
    assign w_a    = w_head.en_addr & w_head.addr_tag;
    assign w_trap = w_head.check & w_head.addr_tag;

    always_comb begin
        w_result = 1'b0;
        case (w_head.mode)
            2'b00:   w_result = w_s | w_a;
            2'b01:   w_result = w_s & w_a;
            2'b10:   w_result = w_s ^ w_a;
            default: w_result = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Bus errors win over the tag check; either one suppresses the tag write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= 1'b0;
            r_exc   <= 1'b0;
            r_spur  <= 1'b0;
        end else begin
            r_we   <= w_pop & ~data_err_i & ~w_trap;
            r_exc  <= w_pop & ~data_err_i & w_trap;
            r_spur <= data_rvalid_i & w_empty;
            if (w_pop) begin
                r_waddr <= w_head.rd;
                r_wdata <= w_result;
            end
        end
    end

    assign ld_ready_o        = ~w_full;
    assign busy_o            = ~w_empty;
    assign rf_tag_we_o       = r_we;
    assign rf_tag_waddr_o    = r_waddr;
    assign rf_tag_wdata_o    = r_wdata;
    assign tag_exc_o         = r_exc;
    assign spurious_rvalid_o = r_spur;
endmodule

// File: tb/tb_riscv_load_tag_prop.sv
// Directed bench for riscv_load_tag_prop: hand-computed vectors checked with
// immediate assertions one cycle after each stimulus edge.
module tb_riscv_load_tag_prop;
    logic        clk;
    logic        rst;
    logic [31:0] tpr_i;
    logic        ld_valid_i;
    logic        ld_ready_o;
    logic        ld_addr_tag_i;
    logic [5:0]  ld_rd_addr_i;
    logic        data_rvalid_i;
    logic        data_rtag_i;
    logic        data_err_i;
    logic        rf_tag_we_o;
    logic [5:0]  rf_tag_waddr_o;
    logic        rf_tag_wdata_o;
    logic        tag_exc_o;
    logic        spurious_rvalid_o;
    logic        busy_o;

    int n_vec;
    int n_err;

    riscv_load_tag_prop #(.DEPTH(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .tpr_i             (tpr_i),
        .ld_valid_i        (ld_valid_i),
        .ld_ready_o        (ld_ready_o),
        .ld_addr_tag_i     (ld_addr_tag_i),
        .ld_rd_addr_i      (ld_rd_addr_i),
        .data_rvalid_i     (data_rvalid_i),
        .data_rtag_i       (data_rtag_i),
        .data_err_i        (data_err_i),
        .rf_tag_we_o       (rf_tag_we_o),
        .rf_tag_waddr_o    (rf_tag_waddr_o),
        .rf_tag_wdata_o    (rf_tag_wdata_o),
        .tag_exc_o         (tag_exc_o),
        .spurious_rvalid_o (spurious_rvalid_o),
        .busy_o            (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_tpr(input logic src, input logic addr,
                                           input logic [1:0] mode, input logic chk);
        logic [31:0] t;
        t = 32'h0000_0000;
        t[18] = src;
        t[19] = addr;
        t[21:20] = mode;
        t[22] = chk;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [5:0] rd, input logic at);
        ld_valid_i    = 1'b1;
        ld_rd_addr_i  = rd;
        ld_addr_tag_i = at;
        tick();
        ld_valid_i    = 1'b0;
        ld_addr_tag_i = 1'b0;
    endtask

    task automatic resp(input logic rtag, input logic err);
        data_rvalid_i = 1'b1;
        data_rtag_i   = rtag;
        data_err_i    = err;
        tick();
        data_rvalid_i = 1'b0;
        data_rtag_i   = 1'b0;
        data_err_i    = 1'b0;
    endtask

    // One load then its response; checks the resulting write.
    task automatic one_shot(input string tag, input logic [31:0] tpr, input logic [5:0] rd,
                            input logic at, input logic rtag, input logic exp_wdata);
        tpr_i = tpr;
        load(rd, at);
        resp(rtag, 1'b0);
        chk({tag, "_we"}, 32'(rf_tag_we_o), 32'd1);
        chk({tag, "_waddr"}, 32'(rf_tag_waddr_o), 32'(rd));
        chk({tag, "_wdata"}, 32'(rf_tag_wdata_o), 32'(exp_wdata));
        $display("vec %s rd=%0d at=%0b rtag=%0b -> we=%0b wdata=%0b", tag, rd, at, rtag,
                 rf_tag_we_o, rf_tag_wdata_o);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        tpr_i = 32'h0;
        ld_valid_i = 1'b0;
        ld_addr_tag_i = 1'b0;
        ld_rd_addr_i = 6'd0;
        data_rvalid_i = 1'b0;
        data_rtag_i = 1'b0;
        data_err_i = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", 32'(ld_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_we", 32'(rf_tag_we_o), 32'd0);
        chk("rst_waddr", 32'(rf_tag_waddr_o), 32'd0);
        chk("rst_wdata", 32'(rf_tag_wdata_o), 32'd0);
        chk("rst_exc", 32'(tag_exc_o), 32'd0);
        chk("rst_spur", 32'(spurious_rvalid_o), 32'd0);
        $display("vec reset: ready=%0b busy=%0b", ld_ready_o, busy_o);

        // OR mode, rvalid two cycles after issue
        tpr_i = mk_tpr(1'b1, 1'b1, 2'b00, 1'b0);
        load(6'd5, 1'b0);
        chk("or_busy", 32'(busy_o), 32'd1);
        tick();
        resp(1'b1, 1'b0);
        chk("or_we", 32'(rf_tag_we_o), 32'd1);
        chk("or_waddr", 32'(rf_tag_waddr_o), 32'd5);
        chk("or_wdata", 32'(rf_tag_wdata_o), 32'd1);
        chk("or_busy_clr", 32'(busy_o), 32'd0);
        $display("vec or: waddr=%0d wdata=%0b", rf_tag_waddr_o, rf_tag_wdata_o);
        tick();
        chk("or_we_pulse", 32'(rf_tag_we_o), 32'd0);

        one_shot("and_0", mk_tpr(1'b1, 1'b1, 2'b01, 1'b0), 6'd7, 1'b1, 1'b0, 1'b0);
        one_shot("and_1", mk_tpr(1'b1, 1'b1, 2'b01, 1'b0), 6'd8, 1'b1, 1'b1, 1'b1);
        one_shot("xor_0", mk_tpr(1'b1, 1'b1, 2'b10, 1'b0), 6'd9, 1'b1, 1'b1, 1'b0);
        one_shot("xor_1", mk_tpr(1'b1, 1'b1, 2'b10, 1'b0), 6'd10, 1'b1, 1'b0, 1'b1);
        one_shot("clr", mk_tpr(1'b1, 1'b1, 2'b11, 1'b0), 6'd11, 1'b1, 1'b1, 1'b0);
        one_shot("no_en", mk_tpr(1'b0, 1'b0, 2'b00, 1'b0), 6'd12, 1'b1, 1'b1, 1'b0);
        one_shot("src_only", mk_tpr(1'b1, 1'b0, 2'b00, 1'b0), 6'd13, 1'b1, 1'b0, 1'b0);
        one_shot("addr_only", mk_tpr(1'b0, 1'b1, 2'b00, 1'b0), 6'd14, 1'b1, 1'b0, 1'b1);
        one_shot("x0", mk_tpr(1'b1, 1'b0, 2'b00, 1'b0), 6'd0, 1'b0, 1'b1, 1'b1);

        // Fill to DEPTH, rewrite TPR, and try an issue while full alongside a response
        tpr_i = mk_tpr(1'b1, 1'b0, 2'b00, 1'b0);
        load(6'd3, 1'b0);
        load(6'd4, 1'b0);
        chk("full_ready", 32'(ld_ready_o), 32'd0);
        chk("full_busy", 32'(busy_o), 32'd1);
        tpr_i = mk_tpr(1'b0, 1'b0, 2'b11, 1'b1);
        ld_valid_i = 1'b1;
        ld_rd_addr_i = 6'd33;
        resp(1'b1, 1'b0);
        ld_valid_i = 1'b0;
        chk("fifo1_we", 32'(rf_tag_we_o), 32'd1);
        chk("fifo1_waddr", 32'(rf_tag_waddr_o), 32'd3);
        chk("fifo1_wdata", 32'(rf_tag_wdata_o), 32'd1);
        chk("fifo1_ready", 32'(ld_ready_o), 32'd1);
        $display("vec fifo1: waddr=%0d wdata=%0b", rf_tag_waddr_o, rf_tag_wdata_o);
        resp(1'b1, 1'b0);
        chk("fifo2_we", 32'(rf_tag_we_o), 32'd1);
        chk("fifo2_waddr", 32'(rf_tag_waddr_o), 32'd4);
        chk("fifo2_wdata", 32'(rf_tag_wdata_o), 32'd1);
        chk("fifo2_busy", 32'(busy_o), 32'd0);
        $display("vec fifo2: waddr=%0d busy=%0b", rf_tag_waddr_o, busy_o);

        // Issue and response in the same cycle with one entry outstanding
        tpr_i = mk_tpr(1'b1, 1'b0, 2'b00, 1'b0);
        load(6'd20, 1'b0);
        ld_valid_i = 1'b1;
        ld_rd_addr_i = 6'd21;
        resp(1'b1, 1'b0);
        ld_valid_i = 1'b0;
        chk("sim_waddr", 32'(rf_tag_waddr_o), 32'd20);
        chk("sim_busy", 32'(busy_o), 32'd1);
        chk("sim_ready", 32'(ld_ready_o), 32'd1);
        resp(1'b0, 1'b0);
        chk("sim2_waddr", 32'(rf_tag_waddr_o), 32'd21);
        chk("sim2_wdata", 32'(rf_tag_wdata_o), 32'd0);
        chk("sim2_busy", 32'(busy_o), 32'd0);
        $display("vec simultaneous: second waddr=%0d", rf_tag_waddr_o);

        // Tag check trap
        tpr_i = mk_tpr(1'b1, 1'b1, 2'b00, 1'b1);
        load(6'd6, 1'b1);
        resp(1'b1, 1'b0);
        chk("trap_exc", 32'(tag_exc_o), 32'd1);
        chk("trap_we", 32'(rf_tag_we_o), 32'd0);
        chk("trap_busy", 32'(busy_o), 32'd0);
        tick();
        chk("trap_exc_pulse", 32'(tag_exc_o), 32'd0);
        $display("vec trap: exc pulse seen");

        // Check bit set but addr tag clear: normal write
        one_shot("chk_clean", mk_tpr(1'b1, 1'b1, 2'b00, 1'b1), 6'd15, 1'b0, 1'b1, 1'b1);
        chk("chk_clean_exc", 32'(tag_exc_o), 32'd0);

        // Bus error beats tag check
        tpr_i = mk_tpr(1'b1, 1'b1, 2'b00, 1'b1);
        load(6'd6, 1'b1);
        resp(1'b1, 1'b1);
        chk("err_exc", 32'(tag_exc_o), 32'd0);
        chk("err_we", 32'(rf_tag_we_o), 32'd0);
        chk("err_busy", 32'(busy_o), 32'd0);
        $display("vec buserr: exc=%0b we=%0b", tag_exc_o, rf_tag_we_o);

        // Spurious response
        resp(1'b1, 1'b0);
        chk("spur", 32'(spurious_rvalid_o), 32'd1);
        chk("spur_we", 32'(rf_tag_we_o), 32'd0);
        chk("spur_busy", 32'(busy_o), 32'd0);
        tick();
        chk("spur_pulse", 32'(spurious_rvalid_o), 32'd0);
        $display("vec spurious: flagged");

        // Reset with two loads outstanding and a response in the same cycle
        tpr_i = mk_tpr(1'b1, 1'b1, 2'b00, 1'b0);
        load(6'd30, 1'b1);
        load(6'd31, 1'b1);
        chk("pre_rst_ready", 32'(ld_ready_o), 32'd0);
        rst = 1'b1;
        resp(1'b1, 1'b0);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_ready", 32'(ld_ready_o), 32'd1);
        chk("mid_rst_we", 32'(rf_tag_we_o), 32'd0);
        chk("mid_rst_waddr", 32'(rf_tag_waddr_o), 32'd0);
        resp(1'b1, 1'b0);
        chk("late_spur", 32'(spurious_rvalid_o), 32'd1);
        chk("late_we", 32'(rf_tag_we_o), 32'd0);
        $display("vec mid-reset: busy=%0b spur=%0b", busy_o, spurious_rvalid_o);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/riscv_load_tag_prop.md
Name: riscv_load_tag_prop

Overview:
- Load-side counterpart of the store tag-enable decoder.
- Tracks outstanding loads from EX/LSU and waits for the in-order memory response, which carries a tag bit.
- Combines the memory data tag with the base-address register tag using the load policy fields of the Tag Propagation Register (TPR), then issues a registered write to the register-file tag bank.
- Also performs the optional load-address tag check and raises a tag exception.

Parameters:
- DEPTH, 2, max outstanding loads (FIFO entries, power of 2, >=1)
- LD_EN_SRC_BIT, 18, TPR bit: propagate memory data tag
- LD_EN_ADDR_BIT, 19, TPR bit: propagate base-address register tag
- LD_MODE_LSB, 20, TPR [LSB+1:LSB] combine mode: 00 OR, 01 AND, 10 XOR, 11 force-clear
- LD_CHECK_BIT, 22, TPR bit: trap when load address tag is set

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- tpr_i  in  32  Tag Propagation Register from CSRs
- ld_valid_i  in  1  EX presents a load whose request is accepted this cycle
- ld_ready_o  out  1  tracker can accept a load
- ld_addr_tag_i  in  1  tag of base-address register
- ld_rd_addr_i  in  6  destination register address
- data_rvalid_i  in  1  memory response valid (in order)
- data_rtag_i  in  1  tag bit of loaded word
- data_err_i  in  1  bus error on this response
- rf_tag_we_o  out  1  register-file tag write enable
- rf_tag_waddr_o  out  6  tag write address
- rf_tag_wdata_o  out  1  tag write data
- tag_exc_o  out  1  one-cycle load tag-check exception pulse
- spurious_rvalid_o  out  1  one-cycle pulse: rvalid while tracker empty
- busy_o  out  1  at least one load outstanding

Behaviour:
- Clock and reset: single clock domain (clk); reset is synchronous and active-high (rst).
- Reset values:
  - All outputs are 0, except ld_ready_o = 1.
  - FIFO is empty, with read and write pointers at 0.
- Issue:
  - A load is accepted when ld_valid_i & ld_ready_o.
  - Each entry stores rd_addr, addr_tag, and a TPR snapshot: en_src, en_addr, mode[1:0], check.
  - TPR changes after issue do not affect an in-flight load.
- ld_ready_o:
  - Equals !full.
  - There is no same-cycle bypass on full, even if a response retires that cycle.
- Simultaneous issue and response with the tracker non-empty and not full:
  - Both occur.
  - Occupancy is unchanged.
  - Pointers advance and wrap modulo DEPTH.
- Response handling, when data_rvalid_i is high and the FIFO is non-empty:
  - Pop the head entry.
  - Compute s = en_src & data_rtag_i and a = en_addr & addr_tag.
  - Combine by mode: 00 gives s|a, 01 gives s&a, 10 gives s^a, 11 gives 0.
  - If en_src = en_addr = 0, the result is 0 regardless of mode.
- Latency: the result is registered, so rvalid in cycle N produces rf_tag_we_o = 1 in cycle N+1 for exactly one cycle, with waddr/wdata valid.
- Tag check:
  - When check = 1 and addr_tag = 1: tag_exc_o pulses in cycle N+1 and rf_tag_we_o is suppressed.
  - The entry is still popped.
- data_err_i = 1:
  - Pop the entry.
  - Suppress rf_tag_we_o.
  - Do not raise tag_exc_o (the LSU reports the bus error).
  - data_err_i takes priority over the tag check.
- Register x0 (waddr 0): the write is still issued; the register file ignores it.
- rvalid while empty:
  - spurious_rvalid_o pulses in N+1.
  - No pop, no write, and the pointers are unchanged.
- busy_o: count != 0, registered from the FIFO state.
- Reset mid-operation: all outstanding entries are discarded and the pending write or exception pulse is cancelled, so outputs are at their reset values in the cycle after rst is sampled high.
- Occupancy counter: width clog2(DEPTH)+1, never exceeds DEPTH, never underflows.

Test Plan:
- Reset with rst = 1 for 2 cycles, then release -> ld_ready_o = 1, busy_o = 0, and all other outputs 0.
- TPR en_src = 1, en_addr = 1, mode 00; load rd = 5, addr_tag = 0; rvalid with rtag = 1 two cycles later -> next cycle we = 1, waddr = 5, wdata = 1.
- Mode 01 with addr_tag = 1 and rtag = 0 -> wdata = 0; mode 10 with both set -> wdata = 0; mode 11 -> wdata = 0.
- DEPTH = 2, back-to-back loads rd = 3 then rd = 4 -> ld_ready_o drops to 0; after each rvalid, writes go to 3 then 4 in order; TPR rewritten between issue and response -> results use the snapshot values.
- check = 1 and addr_tag = 1, response arrives -> tag_exc_o pulses for 1 cycle, no tag write, busy_o clears; repeat with data_err_i = 1 -> no exception and no write.
- rvalid while empty -> spurious_rvalid_o pulses and state is unchanged; rst asserted with 2 loads outstanding -> busy_o = 0 and no write for the late rvalid, which flags spurious.
